// File: rtl/buffer_id_ex.sv
// rtl/buffer_id_ex.sv - ID/EX pipeline register with stall, flush, bubble insertion and stall counter.
// Optional write-back bypass into the captured operands is enabled by defining WB_BYPASS_EN.
module buffer_id_ex #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              stall,
   input  logic              flush,
   input  logic [DATA_W-1:0] rd_data1_in,
   input  logic [DATA_W-1:0] rd_data2_in,
   input  logic [DATA_W-1:0] imm_in,
   input  logic [DATA_W-1:0] pc4_in,
   input  logic [4:0]        rs_in,
   input  logic [4:0]        rt_in,
   input  logic [4:0]        rd_in,
   input  logic [9:0]        ctrl_in,
   input  logic              wb_regwrite,
   input  logic [4:0]        wb_reg,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] rd_data1_out,
   output logic [DATA_W-1:0] rd_data2_out,
   output logic [DATA_W-1:0] imm_out,
   output logic [DATA_W-1:0] pc4_out,
   output logic [4:0]        rs_out,
   output logic [4:0]        rt_out,
   output logic [4:0]        rd_out,
   output logic [9:0]        ctrl_out,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
   logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [DATA_W-1:0] pc4_q, pc4_d;
   logic [4:0]        rs_q, rs_d;
   logic [4:0]        rt_q, rt_d;
   logic [4:0]        rd_q, rd_d;
   logic [9:0]        ctrl_q, ctrl_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic [DATA_W-1:0] op1_sel;
   logic [DATA_W-1:0] op2_sel;

`ifdef WB_BYPASS_EN
   // A register written back this cycle is not yet visible on the read ports.
   always_comb begin
      op1_sel = rd_data1_in;
      op2_sel = rd_data2_in;
      if (wb_regwrite && (wb_reg != 5'd0)) begin
         if (wb_reg == rs_in) op1_sel = wb_data;
         if (wb_reg == rt_in) op2_sel = wb_data;
      end
   end
`else
   logic unused_wb;
   assign unused_wb = ^{wb_regwrite, wb_reg, wb_data};

   always_comb begin
      op1_sel = rd_data1_in;
      op2_sel = rd_data2_in;
   end
`endif

   always_comb begin
      state_d     = state_q;
      rd_data1_d  = rd_data1_q;
      rd_data2_d  = rd_data2_q;
      imm_d       = imm_q;
      pc4_d       = pc4_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      rd_d        = rd_q;
      ctrl_d      = ctrl_q;
      stall_cnt_d = '0;

      if (flush) begin
         state_d = EMPTY;
         ctrl_d  = '0;
      end else if (stall) begin
         if (stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end else begin
            stall_cnt_d = stall_cnt_q;
         end
      end else begin
         rd_data1_d = op1_sel;
         rd_data2_d = op2_sel;
         imm_d      = imm_in;
         pc4_d      = pc4_in;
         rs_d       = rs_in;
         rt_d       = rt_in;
         rd_d       = rd_in;
         // An invalid slot becomes a bubble so it can never write state downstream.
         ctrl_d     = in_valid ? ctrl_in : 10'd0;
         case (state_q)
            EMPTY:   state_d = in_valid ? FULL : EMPTY;
            FULL:    state_d = in_valid ? FULL : EMPTY;
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         rd_data1_q  <= '0;
         rd_data2_q  <= '0;
         imm_q       <= '0;
         pc4_q       <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         ctrl_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rd_data1_q  <= rd_data1_d;
         rd_data2_q  <= rd_data2_d;
         imm_q       <= imm_d;
         pc4_q       <= pc4_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         rd_q        <= rd_d;
         ctrl_q      <= ctrl_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_valid    = (state_q == FULL);
   assign rd_data1_out = rd_data1_q;
   assign rd_data2_out = rd_data2_q;
   assign imm_out      = imm_q;
   assign pc4_out      = pc4_q;
   assign rs_out       = rs_q;
   assign rt_out       = rt_q;
   assign rd_out       = rd_q;
   assign ctrl_out     = ctrl_q;
   assign stall_cnt    = stall_cnt_q;

endmodule
